// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg
// Shared types and constants for the boot-time instruction loader.
//   state_t        : loader FSM states. CHECK exists only when
//                    INSTR_LOADER_CHECKSUM_EN is defined.
//   BYTES_PER_WORD : bytes packed into one instruction word.
//   WORD_W         : instruction word width.
//   CSUM_W         : checksum accumulator width.
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int CSUM_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if
// Bundles the loader's byte-stream input and its instruction-memory
// write port.
//   s_valid, s_data : byte stream from the boot source
//   s_ready         : loader accepts a byte this cycle
//   mem_we          : one-cycle write strobe per packed word
//   mem_addr        : word address of the write
//   mem_wdata       : packed instruction word
// Modports:
//   master : boot-source/memory side (drives the stream, sees writes)
//   slave  : the loader
interface instr_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// byte_packer
// Little-endian byte-to-word assembler shared by the data phase and the
// checksum phase of the loader.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart assembly at lane 0 (new load)
//   load       : accept data into the current lane
//   data       : incoming byte
//   word_next  : assembled word including the byte presented this cycle,
//                so the caller can capture a complete word on the 4th beat
//   word_full  : this load fills the last lane
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane   <= '0;
      word_q <= '0;
    end else if (clear) begin
      lane   <= '0;
      word_q <= '0;
    end else if (load) begin
      word_q <= word_next;
      // Lane counter wraps naturally after the last byte of a word.
      lane   <= lane + 1'b1;
    end
  end

  always_comb begin
    word_next = word_q;
    word_next[lane*8 +: 8] = data;
  end

  assign word_full = load && (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// instr_loader
// Boot-time program loader sitting in front of the core's instruction
// memory. Packs a byte stream little-endian into 32-bit words, writes them
// to consecutive word addresses from 0 and holds the core in reset until
// the requested number of words has been written.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a load (honoured in IDLE and DONE only)
//   len_words : words to load, latched on an accepted start
//   bus       : byte stream in + instruction-memory write port (slave)
//   core_rst  : core reset, released only in DONE without error
//   busy      : load in progress
//   done      : loader in DONE
//   err       : length or checksum error, sticky until next start/rst
// Build option:
//   INSTR_LOADER_CHECKSUM_EN : after the last word, accept a 4-byte
//   little-endian checksum and compare it against the modulo-2**32 sum of
//   all written words; a mismatch sets err and keeps the core in reset.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  instr_loader_if.slave     bus,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              start_ok;
  logic              pk_load;
  logic              pk_full;
  logic [WORD_W-1:0] pk_word_next;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;
`endif

  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
  // s_ready is only high in the stream-accepting states, so this also
  // discards s_valid everywhere else.
  assign pk_load      = bus.s_valid && bus.s_ready;
  assign word_cnt_inc = word_cnt + 1'b1;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .load      (pk_load),
    .data      (bus.s_data),
    .word_next (pk_word_next),
    .word_full (pk_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      word_cnt      <= '0;
      bus.s_ready   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      core_rst      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q    <= len_words;
            word_cnt <= '0;
            err      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            if (len_words == '0) begin
              // Nothing to load: straight to DONE with the core released.
              state    <= ST_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              core_rst <= 1'b0;
            end else if (len_words > CAPACITY) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              err      <= 1'b1;
              core_rst <= 1'b1;
            end else begin
              state       <= ST_RECV;
              done        <= 1'b0;
              busy        <= 1'b1;
              core_rst    <= 1'b1;
              bus.s_ready <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (pk_full) begin
            // Capture the complete word (including this beat's byte) so
            // the WRITE cycle presents registered address and data.
            state         <= ST_WRITE;
            bus.s_ready   <= 1'b0;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= word_cnt[ADDR_W-1:0];
            bus.mem_wdata <= pk_word_next;
          end
        end

        ST_WRITE: begin
          bus.mem_we <= 1'b0;
          word_cnt   <= word_cnt_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum       <= csum + bus.mem_wdata;
`endif
          if (word_cnt_inc == len_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state       <= ST_CHECK;
            bus.s_ready <= 1'b1;
`else
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            core_rst <= err;
`endif
          end else begin
            state       <= ST_RECV;
            bus.s_ready <= 1'b1;
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (pk_full) begin
            state       <= ST_DONE;
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            err         <= (pk_word_next != csum);
            core_rst    <= (pk_word_next != csum);
          end
        end
`endif

        default: begin
          state       <= ST_IDLE;
          bus.s_ready <= 1'b0;
          bus.mem_we  <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          core_rst    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int ADDR_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ADDR_W:0] len_words;
  logic            core_rst;
  logic            busy;
  logic            done;
  logic            err;

  instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_words (len_words),
    .bus       (bus.slave),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [ADDR_W:0] len;
    int              gap;
    logic            exp_err;
  } vec_t;

  wr_t         exp_q[$];
  logic [31:0] wbuf [0:511];
  vec_t        vt [6];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write scoreboard: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {{(32-ADDR_W){1'b0}}, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {{(32-ADDR_W){1'b0}}, bus.mem_addr}, {{(32-ADDR_W){1'b0}}, e.addr});
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    logic rdy;
    int   guard;
    for (int i = 0; i < 6 && $urandom_range(99) < gap_pct; i++) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    guard = 0;
    forever begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        check("s_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] len);
    start     = 1'b1;
    len_words = len;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (done !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  // Full load of wbuf[0..len-1]; the checksum sent (when enabled) is the
  // word sum plus csum_delta.
  task automatic run_load(input logic [ADDR_W:0] len, input int gap_pct,
                          input logic [31:0] csum_delta, input logic exp_err,
                          input string tag);
    logic [31:0] sum;
    logic        bad_len;
    sum     = 32'd0;
    bad_len = (len > (1 << ADDR_W));
    pulse_start(len);
    if (!bad_len) begin
      for (int w = 0; w < int'(len); w++) begin
        exp_q.push_back('{addr: w[ADDR_W-1:0], data: wbuf[w]});
        sum = sum + wbuf[w];
        for (int b = 0; b < 4; b++) send_byte(wbuf[w][8*b +: 8], gap_pct);
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (!bad_len && len != 0) begin
      sum = sum + csum_delta;
      for (int b = 0; b < 4; b++) send_byte(sum[8*b +: 8], gap_pct);
    end
`else
    if (csum_delta != 0) sum = sum + csum_delta;
`endif
    wait_done(tag);
    check({tag, "_err"},      {31'd0, err},      {31'd0, exp_err});
    check({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, exp_err});
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_all_written"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    len_words   = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset defaults
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_rst",  {31'd0, core_rst},    32'd1);
    check("rst_s_ready",   {31'd0, bus.s_ready}, 32'd0);
    check("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
    check("rst_busy",      {31'd0, busy},        32'd0);
    check("rst_done",      {31'd0, done},        32'd0);
    check("rst_err",       {31'd0, err},         32'd0);
    check("rst_mem_wdata", bus.mem_wdata,        32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_core_rst", {31'd0, core_rst}, 32'd1);

    // Single word, with an ignored start pulse in the middle of the load
    pulse_start(9'd1);
    check("sw_busy_after_start", {31'd0, busy},     32'd1);
    check("sw_core_rst_loading", {31'd0, core_rst}, 32'd1);
    exp_q.push_back('{addr: '0, data: 32'h0050_0013});
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    pulse_start(9'd0);
    check("sw_start_ignored", {31'd0, busy}, 32'd1);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    check("sw_mem_we_write", {31'd0, bus.mem_we},  32'd1);
    check("sw_s_ready_write", {31'd0, bus.s_ready}, 32'd0);
    @(posedge clk); #1;
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("sw_in_check", {31'd0, bus.s_ready}, 32'd1);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
`endif
    check("sw_done",     {31'd0, done},     32'd1);
    check("sw_core_rst", {31'd0, core_rst}, 32'd0);
    check("sw_mem_we",   {31'd0, bus.mem_we}, 32'd0);
    check("sw_q_empty",  exp_q.size(),      32'd0);

    // Table-driven loads, each restarting from DONE
    vt[0] = '{len: 9'd1,   gap: 0,  exp_err: 1'b0};
    vt[1] = '{len: 9'd3,   gap: 40, exp_err: 1'b0};
    vt[2] = '{len: 9'd0,   gap: 0,  exp_err: 1'b0};
    vt[3] = '{len: 9'd257, gap: 0,  exp_err: 1'b1};
    vt[4] = '{len: 9'd2,   gap: 25, exp_err: 1'b0};
    vt[5] = '{len: 9'd256, gap: 0,  exp_err: 1'b0};
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < 512; w++) wbuf[w] = $urandom;
      run_load(vt[v].len, vt[v].gap, 32'd0, vt[v].exp_err, $sformatf("vec%0d", v));
    end

    // Reset after 6 bytes of a 2-word load
    wbuf[0] = 32'hDEAD_BEEF;
    wbuf[1] = 32'h1234_5678;
    pulse_start(9'd2);
    exp_q.push_back('{addr: '0, data: wbuf[0]});
    for (int b = 0; b < 4; b++) send_byte(wbuf[0][8*b +: 8], 0);
    send_byte(wbuf[1][7:0], 0);
    send_byte(wbuf[1][15:8], 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_core_rst", {31'd0, core_rst},    32'd1);
    check("mid_rst_s_ready",  {31'd0, bus.s_ready}, 32'd0);
    check("mid_rst_busy",     {31'd0, busy},        32'd0);
    check("mid_rst_q_empty",  exp_q.size(),         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset landing in a WRITE cycle drops mem_we without a clock edge
    pulse_start(9'd1);
    for (int b = 0; b < 4; b++) send_byte(8'hA0 + 8'(b), 0);
    check("wr_rst_we_before", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("wr_rst_we_async", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    wbuf[0] = 32'hCAFE_0001;
    run_load(9'd1, 0, 32'd0, 1'b0, "post_rst");

`ifdef INSTR_LOADER_CHECKSUM_EN
    wbuf[0] = 32'hFFFF_FFFF;
    wbuf[1] = 32'h0000_0002;
    run_load(9'd2, 0, 32'd0, 1'b0, "csum_ok");
    wbuf[0] = 32'hFFFF_FFFF;
    wbuf[1] = 32'h0000_0002;
    run_load(9'd2, 0, 32'hFFFF_FFFF, 1'b1, "csum_bad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader placed directly upstream of the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them sequentially into instruction memory from word address 0. It holds the core in reset until the programmed word count has been written, then releases it.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity is 2**ADDR_W words.
- `clk  in  1`: sole clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `start  in  1`: single-cycle request to begin a load; sampled in IDLE and DONE only.
- `len_words  in  ADDR_W+1`: number of words to load, latched when `start` is accepted.
- `s_valid  in  1`: byte-stream valid.
- `s_data  in  8`: byte-stream data.
- `s_ready  out  1`: loader can accept a byte this cycle.
- `mem_we  out  1`: instruction-memory write strobe; asserted for one cycle per word.
- `mem_addr  out  ADDR_W`: word address of the write.
- `mem_wdata  out  32`: instruction word being written.
- `core_rst  out  1`: reset to the core; high except in DONE with `err`=0.
- `busy  out  1`: load in progress (RECV, WRITE, or CHECK).
- `done  out  1`: high in DONE.
- `err  out  1`: length or checksum error; sticky until the next accepted `start` or `rst`.

## Operation
- States: IDLE, RECV, WRITE, CHECK (present only with the macro), DONE.
- **IDLE:** `s_ready`=0 and `core_rst`=1.
  - On `start`, latch `len_words` and clear the byte counter, word counter, and `err`.
  - If `len_words`=0, go to DONE.
  - If `len_words` > 2**ADDR_W, set `err`=1 and go to DONE without any write.
  - Otherwise go to RECV.
- **RECV:** `s_ready`=1.
  - Each beat with `s_valid`&`s_ready` stores `s_data` into byte lane `byte_cnt`; byte 0 goes to [7:0] and byte 3 to [31:24].
  - `byte_cnt` increments modulo 4. The 4th beat moves to WRITE.
- **WRITE:** one cycle, with `s_ready`=0.
  - `mem_we`=1, `mem_addr`=`word_cnt`, and `mem_wdata`=the packed word.
  - `word_cnt` increments.
  - If the incremented `word_cnt` equals `len`, go to DONE (or CHECK when enabled); otherwise return to RECV.
- **DONE:** `done`=1, `s_ready`=0, and `core_rst`=`err`.
  - `start` in DONE restarts the load with the same acceptance rules as IDLE.
  - A restart reasserts `core_rst` in the cycle after `start`.
- Starting at address 0, addresses are strictly sequential. `word_cnt` never wraps because `len` ≤ 2**ADDR_W is enforced.
- `start` while `busy` is ignored. `s_valid` outside RECV/CHECK is ignored.
- Only a completed `rst` reinitialises the loader. Memory contents already written are not cleared.

## Timing
- Reset values:
  - state = IDLE.
  - `core_rst`=1.
  - `s_ready`, `mem_we`, `busy`, `done`, `err` = 0.
  - `mem_addr`, `mem_wdata`, and all counters = 0.
- All outputs are registered or decoded from state and registers. None depends combinationally on `s_valid` or `s_data`.
- Per-word cost is 4 accepted beats plus 1 WRITE cycle, so peak throughput is 1 word per 5 cycles.
- `done` rises, and `core_rst` falls, on the clock edge after the final WRITE cycle.
- `busy` rises on the edge after `start` is accepted.
- Asserting `rst` mid-load immediately forces IDLE and `core_rst`=1, and deasserts `mem_we` asynchronously.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - A 32-bit accumulator sums every written word, with wrap-around modulo 2**32.
  - After the last WRITE, the loader enters CHECK. It accepts 4 further bytes, packed like RECV, as the expected checksum, then goes to DONE.
  - On a mismatch, `err`=1 and the core stays in reset.
  - `len`=0 skips CHECK.
- Not defined: CHECK and the accumulator are absent; the last WRITE goes directly to DONE.

## Structure
- Package `instr_loader_pkg`: the state enum, `BYTES_PER_WORD`=4, and the checksum width constant.
- Sub-module `byte_packer`: the 2-bit lane counter and 32-bit assembly register, with `clear`/`load` inputs and a `word_full` output. It is reused by RECV and CHECK.

## Test plan
- **Reset defaults:** `rst` pulse → `core_rst`=1, `s_ready`=0, `mem_we`=0, state IDLE.
- **Single word:** `start` with `len`=1, then bytes 0x13,0x00,0x50,0x00 back-to-back → one write with `mem_addr`=0, `mem_wdata`=0x00500013; `done`=1 and `core_rst`=0 on the next edge.
- **Back-pressure gaps:** `len`=3 with random `s_valid` gaps → writes to addresses 0,1,2 with the correct words; no write while `byte_cnt`≠0.
- **Length edge cases:**
  - `len`=0 → DONE after one cycle with no writes.
  - `len`=2**ADDR_W+1 → `err`=1, `core_rst` held at 1, no writes.
- **Reset mid-load:** `rst` asserted after 6 bytes → IDLE immediately; a following `start` with `len`=1 writes address 0.
- **Checksum (macro on):**
  - Words 0xFFFFFFFF and 0x00000002, then checksum 0x00000001 → `err`=0.
  - Checksum 0x00000000 → `err`=1 and `core_rst` stays 1.
